// File: rtl/cfar_pkg.sv
// rtl/cfar_pkg.sv - shared types and header field helpers for the CFAR peak collector
package cfar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PEAKS
    } read_state_t;

    // Count occupies the low bits of both the header FIFO entry and the header word.
    localparam int HDR_CNT_LSB = 0;

    function automatic int cnt_width(input int max_peaks);
        return $clog2(max_peaks + 1);
    endfunction

    // Overflow sits just above the count in a FIFO entry, and in the MSB of the header word.
    function automatic int hdr_entry_ovf_bit(input int max_peaks);
        return cnt_width(max_peaks);
    endfunction

    function automatic int hdr_word_ovf_bit(input int index_width);
        return index_width - 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Full is the registered occupancy, so a same-cycle read never frees room for a write.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cfar_peak_collector.sv
// rtl/cfar_peak_collector.sv - buffers CFAR detections per frame and re-emits them as header + peak stream
module cfar_peak_collector
    import cfar_pkg::*;
#(
    parameter int INDEX_WIDTH = 10,
    parameter int MAX_PEAKS   = 32,
    parameter int HDR_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   det_valid,
    input  logic [INDEX_WIDTH-1:0] det_index,
    input  logic                   det_eop,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_data,
    output logic                   out_hdr,
    output logic                   out_last,
    output logic [7:0]             drop_frames
);
    localparam int CNT_W = cnt_width(MAX_PEAKS);
    localparam int HW    = CNT_W + 1;

    logic                   in_frame, frame_drop, ovf, dropping;
    logic [CNT_W-1:0]       peak_cnt, cnt_next;
    logic                   ovf_next, pk_wr, hdr_wr;
    logic                   pk_full, pk_empty, pk_rd;
    logic                   hdr_full, hdr_empty, hdr_rd;
    logic [INDEX_WIDTH-1:0] pk_rd_data;
    logic [HW-1:0]          hdr_rd_data, hdr_wr_data;

    // Drop decision is latched at frame start; before that the live header-full flag decides.
    assign dropping    = in_frame ? frame_drop : hdr_full;
    assign pk_wr       = det_valid && !dropping && !pk_full;
    assign hdr_wr      = det_eop && !dropping;
    assign cnt_next    = peak_cnt + CNT_W'(pk_wr);
    assign ovf_next    = ovf | (det_valid && !dropping && pk_full);
    assign hdr_wr_data = {ovf_next, cnt_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            in_frame    <= 1'b0;
            frame_drop  <= 1'b0;
            peak_cnt    <= '0;
            ovf         <= 1'b0;
            drop_frames <= '0;
        end else if (det_eop) begin
            in_frame   <= 1'b0;
            frame_drop <= 1'b0;
            peak_cnt   <= '0;
            ovf        <= 1'b0;
            if (dropping && drop_frames != 8'hFF) drop_frames <= drop_frames + 8'd1;
        end else if (det_valid) begin
            in_frame   <= 1'b1;
            frame_drop <= dropping;
            peak_cnt   <= cnt_next;
            ovf        <= ovf_next;
        end
    end

    sync_fifo #(.WIDTH(INDEX_WIDTH), .DEPTH(MAX_PEAKS)) u_peak_fifo (
        .clk(clk), .reset(reset), .wr_en(pk_wr), .wr_data(det_index),
        .rd_en(pk_rd), .rd_data(pk_rd_data), .full(pk_full), .empty(pk_empty)
    );

    sync_fifo #(.WIDTH(HW), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
        .clk(clk), .reset(reset), .wr_en(hdr_wr), .wr_data(hdr_wr_data),
        .rd_en(hdr_rd), .rd_data(hdr_rd_data), .full(hdr_full), .empty(hdr_empty)
    );

    read_state_t            state, state_next;
    logic [CNT_W-1:0]       rem, rem_n, hdr_cnt;
    logic [INDEX_WIDTH-1:0] hdr_word, data_n;
    logic                   valid_n, hdr_n, last_n, load_peak, handshake;

    assign hdr_cnt   = hdr_rd_data[HDR_CNT_LSB +: CNT_W];
    assign handshake = out_valid && out_ready;

    always_comb begin
        hdr_word = '0;
        hdr_word[hdr_word_ovf_bit(INDEX_WIDTH)] = hdr_rd_data[hdr_entry_ovf_bit(MAX_PEAKS)];
        hdr_word[HDR_CNT_LSB +: CNT_W] = hdr_cnt;
    end

    // Outputs are computed one cycle ahead and registered; the header stays at the
    // FIFO head until its frame is fully delivered.
    always_comb begin
        state_next = state;
        valid_n    = out_valid;
        data_n     = out_data;
        hdr_n      = out_hdr;
        last_n     = out_last;
        rem_n      = rem;
        pk_rd      = 1'b0;
        hdr_rd     = 1'b0;
        load_peak  = 1'b0;
        case (state)
            IDLE: begin
                if (!hdr_empty) begin
                    state_next = HDR;
                    valid_n    = 1'b1;
                    hdr_n      = 1'b1;
                    last_n     = (hdr_cnt == '0);
                    data_n     = hdr_word;
                    rem_n      = hdr_cnt;
                end
            end
            HDR: begin
                if (handshake) begin
                    if (rem != '0) begin
                        state_next = PEAKS;
                        load_peak  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        hdr_rd     = 1'b1;
                        valid_n    = 1'b0;
                        hdr_n      = 1'b0;
                        last_n     = 1'b0;
                    end
                end
            end
            PEAKS: begin
                if (handshake) begin
                    if (out_last) begin
                        state_next = IDLE;
                        hdr_rd     = 1'b1;
                        valid_n    = 1'b0;
                        last_n     = 1'b0;
                    end else begin
                        load_peak = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (load_peak) begin
            data_n = pk_rd_data;
            hdr_n  = 1'b0;
            last_n = (rem == CNT_W'(1));
            rem_n  = rem - CNT_W'(1);
            pk_rd  = !pk_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hdr   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_next;
            rem       <= rem_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_hdr   <= hdr_n;
            out_last  <= last_n;
        end
    end

endmodule

// File: tb/tb_cfar_peak_collector.sv
// tb/tb_cfar_peak_collector.sv - self-checking bench for cfar_peak_collector
module tb_cfar_peak_collector;
    localparam int IW = 10;
    localparam int MP = 32;
    localparam int HD = 4;

    logic          clk = 1'b0;
    logic          reset, det_valid, det_eop, out_ready, out_valid, out_hdr, out_last;
    logic [IW-1:0] det_index, out_data;
    logic [7:0]    drop_frames;

    always #5 clk = ~clk;

    cfar_peak_collector #(.INDEX_WIDTH(IW), .MAX_PEAKS(MP), .HDR_DEPTH(HD)) dut (
        .clk(clk), .reset(reset), .det_valid(det_valid), .det_index(det_index),
        .det_eop(det_eop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_hdr(out_hdr), .out_last(out_last),
        .drop_frames(drop_frames)
    );

    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];
    int          ready_mode = 1;
    int          hdr_pend = 0;
    int          pk_pend = 0;
    int          exp_drops = 0;
    int          fidx[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic        stall_q = 1'b0;
    logic [31:0] stall_word;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q)
                    chk("hold_while_stalled", 32'({out_valid, out_hdr, out_last, out_data}),
                        32'(32'h1000 | stall_word));
                if (out_valid && out_ready) rx_q.push_back(32'({out_hdr, out_last, out_data}));
                stall_q    = out_valid && !out_ready;
                stall_word = 32'({out_hdr, out_last, out_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a frame is kept whole if fewer than HD headers wait; the peak store keeps the
    // first peaks that fit in MP, and the header reports that kept count plus an overflow bit.
    task automatic model_frame(input int n);
        int stored;
        int hw;
        if (hdr_pend >= HD) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            stored = (n < MP - pk_pend) ? n : MP - pk_pend;
            hw = ((n > stored) ? (1 << (IW - 1)) : 0) + stored;
            exp_q.push_back(32'(2048 + ((stored == 0) ? 1024 : 0) + hw));
            for (int i = 0; i < stored; i++)
                exp_q.push_back(32'(((i == stored - 1) ? 1024 : 0) + fidx[i]));
            hdr_pend++;
            pk_pend += stored;
        end
    endtask

    task automatic send_frame(input int n, input bit merged);
        for (int i = 0; i < n; i++) begin
            det_valid = 1'b1;
            det_index = IW'(fidx[i]);
            det_eop   = merged && (i == n - 1);
            tick();
        end
        if (!(merged && n > 0)) begin
            det_valid = 1'b0;
            det_eop   = 1'b1;
            tick();
        end
        det_valid = 1'b0;
        det_eop   = 1'b0;
        model_frame(n);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        int n;
        while (rx_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_word_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
        hdr_pend = 0;
        pk_pend  = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        reset = 1'b1; det_valid = 1'b0; det_eop = 1'b0; det_index = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_hdr", 32'(out_hdr), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_drop_frames", 32'(drop_frames), 32'd0);
        tick();

        fidx[0] = 5; fidx[1] = 100; fidx[2] = 1023;
        ready_mode = 1;
        send_frame(3, 0);
        @(negedge clk);
        chk("eop_plus1_not_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("eop_plus2_header", 32'({out_valid, out_hdr, out_data}), 32'h0C03);
        drain("three_peaks");

        send_frame(0, 0);
        drain("empty_frame");

        ready_mode = 0;
        for (int i = 0; i < 34; i++) fidx[i] = int'($urandom_range(0, 1023));
        send_frame(34, 0);
        ready_mode = 1;
        drain("overflow");

        fidx[0] = 3; fidx[1] = 7;
        send_frame(2, 1);
        drain("merged_eop");

        ready_mode = 0;
        for (int f = 0; f < 5; f++) begin
            fidx[0] = 10 * f + 1;
            send_frame(1, 0);
        end
        @(negedge clk);
        chk("drop_frames_after_five", 32'(drop_frames), 32'(exp_drops));
        tick();
        ready_mode = 1;
        drain("header_queue_full");

        ready_mode = 2;
        for (int i = 0; i < 3; i++) fidx[i] = int'($urandom_range(0, 1023));
        send_frame(3, 0);
        drain("toggle_ready");

        for (int k = 0; k < 8; k++) begin
            int n;
            n = int'($urandom_range(0, 40));
            for (int i = 0; i < n; i++) fidx[i] = int'($urandom_range(0, 1023));
            ready_mode = int'($urandom_range(1, 3));
            send_frame(n, 1'($urandom_range(0, 1)));
            drain($sformatf("random%0d", k));
        end

        ready_mode = 1;
        for (int i = 0; i < 6; i++) fidx[i] = int'($urandom_range(0, 1023));
        send_frame(6, 0);
        seen = 0;
        for (int t = 0; t < 50 && seen == 0; t++) begin
            @(negedge clk);
            if (out_valid && !out_hdr) seen = 1;
        end
        chk("reached_peaks_phase", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_out_valid", 32'(out_valid), 32'd0);
        chk("after_reset_drop_frames", 32'(drop_frames), 32'd0);
        rx_q.delete();
        exp_q.delete();
        hdr_pend = 0;
        pk_pend = 0;
        exp_drops = 0;
        tick();
        for (int i = 0; i < 4; i++) fidx[i] = int'($urandom_range(0, 1023));
        send_frame(4, 0);
        drain("after_reset_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cfar_peak_collector.md
# cfar_peak_collector

Downstream stage of the CFAR detector. It captures the detection strobes (`max_valid` / `index_out`) and the end-of-packet marker that the detector emits for each 1024-bin frame. It buffers them and re-emits each frame as a framed stream with valid/ready handshaking: one header word, then the peak indices. This decouples the backpressure-free detector from a slower consumer (DMA / host readout).

## Interface
Parameters:
- `INDEX_WIDTH`, 10: bin index width; must be ≥ `$clog2(MAX_PEAKS+1)+1`.
- `MAX_PEAKS`, 32: peak FIFO depth, which is also the maximum peaks stored per frame.
- `HDR_DEPTH`, 4: header FIFO depth, i.e. the number of frames queued.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `det_valid`, in, 1: detection strobe from the CFAR detector.
- `det_index`, in, `INDEX_WIDTH`: bin index of the detection.
- `det_eop`, in, 1: last bin of the frame has been processed; closes the frame.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: consumer ready.
- `out_data`, out, `INDEX_WIDTH`: header word or peak index.
- `out_hdr`, out, 1: `out_data` is a header word.
- `out_last`, out, 1: last word of the frame.
- `drop_frames`, out, 8: count of discarded frames; saturates at 255.

## Operation
- Two instances of the sub-FIFO:
  - Peak FIFO: depth `MAX_PEAKS`, entry width `INDEX_WIDTH`.
  - Header FIFO: depth `HDR_DEPTH`, entry = {overflow, count}.
- Frame start is the first cycle with `det_valid` or `det_eop` after reset or after the previous `det_eop`.
  - At frame start, if the header FIFO is full, `frame_drop` is set.
  - While `frame_drop` is set, all detections of the frame are discarded. The frame's `det_eop` clears `frame_drop` and increments `drop_frames`.
- Accepted frame, on `det_valid`:
  - Peak FIFO not full: write `det_index` and increment `peak_cnt`.
  - Peak FIFO full: drop the peak and set the sticky `ovf` bit.
- On `det_eop` for an accepted frame:
  - Push {`ovf`, `peak_cnt`} into the header FIFO.
  - Clear `peak_cnt` and `ovf`.
  - If `det_valid` is high in the same cycle, that detection belongs to the closing frame and is included in the count.
- Header word layout: bit `INDEX_WIDTH-1` = overflow; low `$clog2(MAX_PEAKS+1)` bits = count; all other bits 0.
- Read FSM states: `IDLE`, `HDR`, `PEAKS`.
  - `IDLE` → `HDR` when the header FIFO is non-empty.
  - `HDR`: present the header with `out_hdr=1`. `out_last=1` if count = 0.
    - On handshake: go to `PEAKS` if count > 0; otherwise pop the header and go to `IDLE`.
  - `PEAKS`: present peak FIFO entries and decrement the remaining count on each handshake. The final peak has `out_last=1`.
    - On its handshake: pop the header and go to `IDLE`.
- A peak is never presented before its frame header has been pushed. Write and read of the same FIFO in the same cycle are allowed.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_hdr=0`, `out_last=0`, `drop_frames=0`, FSM=`IDLE`, both FIFOs empty, `frame_drop=0`, `peak_cnt=0`, `ovf=0`.
- All outputs are registered.
  - `det_eop` in cycle N → header presented with `out_valid=1` in cycle N+2 at the earliest (write at N, FSM sees non-empty at N+1).
  - With `out_ready` held at 1, one word per cycle is delivered after the header.
- Handshake completes on `out_valid && out_ready`.
  - While `out_valid=1 && !out_ready`, `out_data`, `out_hdr` and `out_last` hold stable.
  - `out_valid` never drops without a handshake.
- FIFO full: the write is ignored; the full flag is evaluated before a same-cycle read frees a slot.
- `reset` mid-frame or mid-readout: all state is flushed at the next edge. Partially emitted frames are abandoned without a trailing `out_last`.

## Structure
- Package `cfar_pkg` holds:
  - `read_state_t` enum (`IDLE`, `HDR`, `PEAKS`).
  - Header field positions.
  - `CNT_WIDTH = $clog2(MAX_PEAKS+1)` helper function.
- Sub-module `sync_fifo`: parameterised width and depth, `reset` synchronous, outputs `full`/`empty`, first-word-fall-through. It is instantiated twice.

## Test plan
- Peaks at 5, 100, 1023 then `det_eop`, `out_ready=1`:
  - header `out_hdr=1`, `out_data=3`;
  - then 5, 100, 1023;
  - `out_last=1` only on 1023.
- Frame with no peaks, `det_eop` only → single header, count 0, `out_hdr=1`, `out_last=1`.
- 34 peaks in one frame, `MAX_PEAKS=32`, `out_ready=0` until `det_eop`:
  - header overflow bit set, count 32;
  - 32 indices follow.
- `det_valid` with index 7 and `det_eop` in the same cycle after one earlier peak at 3 → header count 2; peaks 3, 7.
- Five one-peak frames with `out_ready=0`, `HDR_DEPTH=4`, then release `out_ready`:
  - `drop_frames=1`;
  - four frames emitted in order.
- `out_ready` toggling every cycle through a 3-peak frame → every word held stable while stalled; no loss or duplication.
- `reset` asserted mid-`PEAKS` → next cycle `out_valid=0`; the next frame emits correctly from its header.
